div32u_arbiter: RTL and testbench

- Shares one Div32U unsigned divider between two requesters, using round-robin arbitration.
- Sequences each operation: latches operands, pulses the divider's start/restart input, counts the fixed divider latency, captures the quotient and remainder, and returns them on a valid/ready response channel tagged with the requester ID.
- Divide-by-zero is handled locally, without starting the divider.

---
 rtl/div32u_arbiter.sv | 156 +++++++++++++++
 tb/tb_div32u_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div32u_arbiter.sv
// Round-robin front end sharing one Div32U between two requesters; LATENCY+2 cycles accept-to-response (1 for divide-by-zero).
// Requesters stall (ready low) until the block is IDLE; the response is held stable while rsp_ready is low.
module div32u_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dived,
  input  logic [WIDTH-1:0] req0_divor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dived,
  input  logic [WIDTH-1:0] req1_divor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_quoti,
  output logic [WIDTH-1:0] rsp_remai,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dived,
  output logic [WIDTH-1:0] div_divor,
  input  logic [WIDTH-1:0] div_quoti,
  input  logic [WIDTH-1:0] div_remai
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             div_start_q, div_start_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_quoti_q, rsp_quoti_d;
  logic [WIDTH-1:0] rsp_remai_q, rsp_remai_d;
  logic [WIDTH-1:0] div_dived_q, div_dived_d;
  logic [WIDTH-1:0] div_divor_q, div_divor_d;

  logic             grant0, grant1;
  logic             accept;
  logic             sel_id;
  logic [WIDTH-1:0] sel_dived, sel_divor;

  // Tie goes to the requester that did not win last; rst gating keeps ready low during reset.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = rst & (state_q == S_IDLE) & grant0;
    req1_ready = rst & (state_q == S_IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    sel_id     = req1_ready;
    sel_dived  = req1_ready ? req1_dived : req0_dived;
    sel_divor  = req1_ready ? req1_divor : req0_divor;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_quoti_d  = rsp_quoti_q;
    rsp_remai_d  = rsp_remai_q;
    div_dived_d  = div_dived_q;
    div_divor_d  = div_divor_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_dived_d  = sel_dived;
          div_divor_d  = sel_divor;
          rsp_id_d     = sel_id;
          last_grant_d = sel_id;
          if (sel_divor == '0) begin
            rsp_quoti_d = '1;
            rsp_remai_d = sel_dived;
            state_d     = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Counter reaches LATENCY on this edge: divider outputs are final.
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          rsp_quoti_d = div_quoti;
          rsp_remai_d = div_remai;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    div_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      div_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_quoti_q  <= '0;
      rsp_remai_q  <= '0;
      div_dived_q  <= '0;
      div_divor_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      div_start_q  <= div_start_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_quoti_q  <= rsp_quoti_d;
      rsp_remai_q  <= rsp_remai_d;
      div_dived_q  <= div_dived_d;
      div_divor_q  <= div_divor_d;
    end
  end

  assign div_start = div_start_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_quoti = rsp_quoti_q;
  assign rsp_remai = rsp_remai_q;
  assign div_dived = div_dived_q;
  assign div_divor = div_divor_q;

endmodule

// File: tb/tb_div32u_arbiter.sv
// Scoreboarded bench for div32u_arbiter with a behavioural Div32U stand-in.
module tb_div32u_arbiter;
  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_dived, req0_divor, req1_dived, req1_divor;
  logic        rsp_valid, rsp_ready, rsp_id, busy, div_start;
  logic [31:0] rsp_quoti, rsp_remai, div_dived, div_divor, div_quoti, div_remai;

  div32u_arbiter #(.WIDTH(32), .LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dived(req0_dived), .req0_divor(req0_divor),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dived(req1_dived), .req1_divor(req1_divor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quoti(rsp_quoti), .rsp_remai(rsp_remai), .busy(busy),
    .div_start(div_start), .div_dived(div_dived), .div_divor(div_divor),
    .div_quoti(div_quoti), .div_remai(div_remai)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Div32U stand-in: outputs are noise until LAT edges after the restart edge.
  int dcnt = LAT;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt      <= 1;
      div_quoti <= $urandom;
      div_remai <= $urandom;
    end else if (dcnt < LAT) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == LAT) begin
        div_quoti <= (div_divor != 0) ? div_dived / div_divor : 32'hFFFF_FFFF;
        div_remai <= (div_divor != 0) ? div_dived % div_divor : div_dived;
      end else begin
        div_quoti <= $urandom;
        div_remai <= $urandom;
      end
    end
  end

  // Reference model: one operation in flight, round-robin with a tie-break pointer.
  typedef struct packed {
    logic        id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        ent;
  bit          m_busy = 0, m_last = 1, was_busy, e0, e1, acc0, newrsp;
  int          acc_cyc = 0;
  bit          acc_dz = 0;
  logic [31:0] acc_a, acc_b, a, b;
  bit          pv = 0, pr = 0;
  logic        pid;
  logic [31:0] pq, prr;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      m_busy = 0;
      m_last = 1;
      pv     = 0;
      pr     = 0;
    end else begin
      was_busy = m_busy;
      e0 = 0;
      e1 = 0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e0 = m_last;
          e1 = !m_last;
        end else begin
          e0 = req0_valid;
          e1 = req1_valid;
        end
      end
      if (req0_valid || req1_valid || req0_ready || req1_ready) begin
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
      end
      check("busy", 32'(busy), 32'(m_busy));
      check("div_start", 32'(div_start), 32'(m_busy && !acc_dz && cyc == acc_cyc + 1));
      if (div_start) begin
        check("div_dived", div_dived, acc_a);
        check("div_divor", div_divor, acc_b);
      end

      newrsp = rsp_valid && (!pv || pr);
      if (newrsp) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          ent = sb_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(ent.id));
          check("rsp_quoti", rsp_quoti, ent.q);
          check("rsp_remai", rsp_remai, ent.r);
          check("rsp_latency", 32'(cyc) - ent.acc_cyc, ent.dz ? 32'd1 : 32'(LAT + 2));
        end
      end else if (rsp_valid) begin
        check("hold_id", 32'(rsp_id), 32'(pid));
        check("hold_quoti", rsp_quoti, pq);
        check("hold_remai", rsp_remai, prr);
      end else if (pv && !pr) begin
        check("rsp_valid_dropped", 32'(rsp_valid), 32'(1));
      end
      if (rsp_valid && rsp_ready) m_busy = 0;

      if (!was_busy && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        acc0    = req0_valid && req0_ready;
        a       = acc0 ? req0_dived : req1_dived;
        b       = acc0 ? req0_divor : req1_divor;
        acc_a   = a;
        acc_b   = b;
        acc_dz  = (b == 0);
        acc_cyc = cyc;
        m_busy  = 1;
        m_last  = !acc0;
        sb_q.push_back('{id: !acc0, q: (b == 0) ? 32'hFFFF_FFFF : a / b,
                         r: (b == 0) ? a : a % b, dz: (b == 0), acc_cyc: 32'(cyc)});
      end
      pv  = rsp_valid;
      pr  = rsp_ready;
      pid = rsp_id;
      pq  = rsp_quoti;
      prr = rsp_remai;
    end
  end

  // Present one operation and hold it until accepted, then scramble the operands.
  task automatic issue(input int id, input logic [31:0] dv, input logic [31:0] ds);
    int t = 0;
    if (id == 0) begin
      req0_valid = 1; req0_dived = dv; req0_divor = ds;
    end else begin
      req1_valid = 1; req1_dived = dv; req1_divor = ds;
    end
    forever begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) break;
      t++;
      if (t > 3000) begin
        check("accept_timeout", 32'(id), 32'(id + 2));
        break;
      end
    end
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_valid = 0; req0_dived = $urandom; req0_divor = $urandom;
    end else begin
      req1_valid = 0; req1_dived = $urandom; req1_divor = $urandom;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_busy || sb_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        check("idle_timeout", 32'(sb_q.size()), 32'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_divor();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return $urandom;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  bit done = 0;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_dived = 0; req0_divor = 0; req1_dived = 0; req1_divor = 0;

    // Contention across reset release: requester 0 wins the first tie.
    fork
      issue(0, 32'd100, 32'd7);
      issue(1, 32'hFFFF_FFFF, 32'h10);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'(0));
        check("rst_req1_ready", 32'(req1_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_div_start", 32'(div_start), 32'(0));
        check("rst_div_dived", div_dived, 32'(0));
        check("rst_rsp_quoti", rsp_quoti, 32'(0));
        rst = 1;
      end
    join
    wait_idle();

    issue(1, 32'd50, 32'd5);
    issue(1, 32'd4, 32'h8000_0007);
    issue(0, 32'd7, 32'd4);
    issue(0, 32'h1234, 32'd0);
    wait_idle();

    // Backpressure with a competing requester waiting.
    rsp_ready = 0;
    fork
      issue(0, 32'd1000, 32'd3);
      begin
        repeat (2) @(posedge clk);
        #1;
        issue(1, 32'd77, 32'd7);
      end
      begin
        for (int t = 0; t < 200 && !rsp_valid; t++) @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        repeat (10) @(posedge clk);
        #1;
        rsp_ready = 1;
      end
    join
    wait_idle();

    // Reset while the divider is counting: the operation is abandoned.
    issue(0, 32'hDEAD, 32'd13);
    repeat (16) @(posedge clk);
    #2;
    rst = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_div_dived", div_dived, 32'(0));
    check("mid_rst_div_divor", div_divor, 32'(0));
    check("mid_rst_rsp_remai", rsp_remai, 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    repeat (5) @(posedge clk);
    #1;
    issue(0, 32'd9, 32'd3);
    wait_idle();

    // Random traffic on both ports with random response backpressure.
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            issue(0, $urandom, rnd_divor());
          end
          for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            issue(1, $urandom, rnd_divor());
          end
        join
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    rsp_ready = 1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
